sort_stream_adapter: RTL and testbench

Stream-side front/back end for the 8-lane 32-bit pipelined bitonic sorter. Collects up to eight words from a valid/ready input stream, drives them in parallel into the sorter, holds them stable for the sorter's pipeline latency, captures the sorted result, and re-serializes it onto a valid/ready output stream. Short frames, terminated with `s_last`, are padded so that the pad values sort to the tail and are dropped. One frame is in flight at a time.

---
 rtl/sort_stream_adapter.sv | 221 ++++++++++++++++++++++
 tb/tb_sort_stream_adapter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sort_stream_adapter.sv
// sort_stream_adapter
// Collects up to eight words from a valid/ready input stream and presents
// them in parallel to an external 8-lane pipelined sorter. It holds the lanes
// stable while the sorter runs, captures the sorted lanes, then replays the
// first n of them on a valid/ready output stream. One frame is in flight at a
// time. Short frames are padded with a value that always sorts to the tail,
// so only the first n sorted words are emitted.
module sort_stream_adapter #(
  parameter int WIDTH    = 32,
  parameter int SORT_LAT = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dir_cfg,
  input  logic             s_valid,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_last,
  output logic             s_ready,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  input  logic             m_ready,
  output logic [WIDTH-1:0] sort_i0,
  output logic [WIDTH-1:0] sort_i1,
  output logic [WIDTH-1:0] sort_i2,
  output logic [WIDTH-1:0] sort_i3,
  output logic [WIDTH-1:0] sort_i4,
  output logic [WIDTH-1:0] sort_i5,
  output logic [WIDTH-1:0] sort_i6,
  output logic [WIDTH-1:0] sort_i7,
  output logic             sort_dir,
  output logic             sort_en,
  output logic             sort_rst,
  input  logic [WIDTH-1:0] sort_o0,
  input  logic [WIDTH-1:0] sort_o1,
  input  logic [WIDTH-1:0] sort_o2,
  input  logic [WIDTH-1:0] sort_o3,
  input  logic [WIDTH-1:0] sort_o4,
  input  logic [WIDTH-1:0] sort_o5,
  input  logic [WIDTH-1:0] sort_o6,
  input  logic [WIDTH-1:0] sort_o7
);

  localparam int LANES = 8;
  localparam int TW    = (SORT_LAT > 1) ? $clog2(SORT_LAT) : 1;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    SORT  = 2'd1,
    CAPT  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;

  // cnt: next ibuf slot while filling; n: word count of the frame in flight
  logic [2:0]       cnt;
  logic [3:0]       n;
  logic [TW-1:0]    timer;
  logic [2:0]       idx;

  logic [WIDTH-1:0] ibuf       [LANES];
  logic [WIDTH-1:0] obuf       [LANES];
  logic [WIDTH-1:0] lane       [LANES];
  logic [WIDTH-1:0] sort_o_arr [LANES];

  logic             in_fire;
  logic             in_end;
  logic             out_fire;
  logic             last_beat;
  logic             sort_done;

  // Pad value that sorts behind every real word for the latched direction:
  // all-ones is never smaller than anything (ascending), all-zeros is never
  // larger than anything (descending).
  function automatic logic [WIDTH-1:0] pad_value(input logic dir);
    return dir ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
  endfunction

  // The sorter shares our reset, just with the opposite polarity.
  assign sort_rst = ~reset;

  // Handshake qualifiers are derived from state directly so the output
  // decode below does not loop back on its own outputs.
  assign in_fire   = (state == FILL) & s_valid;
  assign in_end    = in_fire & (s_last | (cnt == 3'd7));
  assign out_fire  = (state == DRAIN) & m_ready;
  assign last_beat = ({1'b0, idx} == (n - 4'd1));
  assign sort_done = (timer == TW'(SORT_LAT - 1));

  assign sort_o_arr[0] = sort_o0;
  assign sort_o_arr[1] = sort_o1;
  assign sort_o_arr[2] = sort_o2;
  assign sort_o_arr[3] = sort_o3;
  assign sort_o_arr[4] = sort_o4;
  assign sort_o_arr[5] = sort_o5;
  assign sort_o_arr[6] = sort_o6;
  assign sort_o_arr[7] = sort_o7;

  // State register; reset abandons any partial frame and returns to FILL.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and stream/sorter control decode.
  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    m_valid   = 1'b0;
    m_last    = 1'b0;
    m_data    = '0;
    sort_en   = 1'b0;
    unique case (state)
      FILL: begin
        s_ready = 1'b1;
        if (in_end) begin
          state_nxt = SORT;
        end
      end
      SORT: begin
        sort_en = 1'b1;
        if (sort_done) begin
          state_nxt = CAPT;
        end
      end
      CAPT: begin
        state_nxt = DRAIN;
      end
      DRAIN: begin
        m_valid = 1'b1;
        m_data  = obuf[idx];
        m_last  = last_beat;
        if (out_fire && last_beat) begin
          state_nxt = FILL;
        end
      end
      default: begin
        state_nxt = FILL;
      end
    endcase
  end

  // Input collection: store each accepted word, latch the frame direction on
  // the first word, and record the frame length when the frame closes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt      <= 3'd0;
      n        <= 4'd0;
      sort_dir <= 1'b0;
      for (int k = 0; k < LANES; k++) begin
        ibuf[k] <= '0;
      end
    end else if (in_fire) begin
      ibuf[cnt] <= s_data;
      if (cnt == 3'd0) begin
        sort_dir <= dir_cfg;
      end
      if (in_end) begin
        n   <= {1'b0, cnt} + 4'd1;
        cnt <= 3'd0;
      end else begin
        cnt <= cnt + 3'd1;
      end
    end
  end

  // Sort window timer: counts the enabled sorter edges, wraps on exit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      timer <= '0;
    end else if (state == SORT) begin
      timer <= sort_done ? '0 : timer + TW'(1);
    end
  end

  // Capture the sorted lanes once the sorter pipeline has fully drained.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < LANES; k++) begin
        obuf[k] <= '0;
      end
    end else if (state == CAPT) begin
      for (int k = 0; k < LANES; k++) begin
        obuf[k] <= sort_o_arr[k];
      end
    end
  end

  // Output read pointer: starts at lane 0 after capture, advances per beat.
  always_ff @(posedge clk) begin
    if (!reset) begin
      idx <= 3'd0;
    end else if (state == CAPT) begin
      idx <= 3'd0;
    end else if (out_fire) begin
      idx <= last_beat ? 3'd0 : idx + 3'd1;
    end
  end

  // Lane drive: real words below n, pad above; stable until the next fill.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      lane[k] = (4'(k) < n) ? ibuf[k] : pad_value(sort_dir);
    end
  end

  assign sort_i0 = lane[0];
  assign sort_i1 = lane[1];
  assign sort_i2 = lane[2];
  assign sort_i3 = lane[3];
  assign sort_i4 = lane[4];
  assign sort_i5 = lane[5];
  assign sort_i6 = lane[6];
  assign sort_i7 = lane[7];

endmodule

// File: tb/tb_sort_stream_adapter.sv
// Bench for sort_stream_adapter: a behavioural pipelined sorter drives the
// sort_o lanes, a frame-level model predicts each output frame, and one
// negedge monitor compares the DUT against it every cycle.
module tb_sort_stream_adapter;
  localparam int W   = 32;
  localparam int LAT = 7;
  typedef logic [W-1:0] word_t;
  typedef logic [7:0][W-1:0] vec_t;

  logic  clk = 1'b0;
  logic  reset, dir_cfg, s_valid, s_last, s_ready;
  logic  m_valid, m_last, m_ready;
  word_t s_data, m_data;
  word_t sort_i0, sort_i1, sort_i2, sort_i3, sort_i4, sort_i5, sort_i6, sort_i7;
  word_t sort_o0, sort_o1, sort_o2, sort_o3, sort_o4, sort_o5, sort_o6, sort_o7;
  logic  sort_dir, sort_en, sort_rst;
  vec_t  lanes_in;
  vec_t  pipe [LAT];

  always #5 clk = ~clk;

  sort_stream_adapter #(.WIDTH(W), .SORT_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .dir_cfg(dir_cfg),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
    .sort_i0(sort_i0), .sort_i1(sort_i1), .sort_i2(sort_i2), .sort_i3(sort_i3),
    .sort_i4(sort_i4), .sort_i5(sort_i5), .sort_i6(sort_i6), .sort_i7(sort_i7),
    .sort_dir(sort_dir), .sort_en(sort_en), .sort_rst(sort_rst),
    .sort_o0(sort_o0), .sort_o1(sort_o1), .sort_o2(sort_o2), .sort_o3(sort_o3),
    .sort_o4(sort_o4), .sort_o5(sort_o5), .sort_o6(sort_o6), .sort_o7(sort_o7)
  );

  assign lanes_in = {sort_i7, sort_i6, sort_i5, sort_i4, sort_i3, sort_i2, sort_i1, sort_i0};
  assign sort_o0 = pipe[LAT-1][0];
  assign sort_o1 = pipe[LAT-1][1];
  assign sort_o2 = pipe[LAT-1][2];
  assign sort_o3 = pipe[LAT-1][3];
  assign sort_o4 = pipe[LAT-1][4];
  assign sort_o5 = pipe[LAT-1][5];
  assign sort_o6 = pipe[LAT-1][6];
  assign sort_o7 = pipe[LAT-1][7];

  function automatic vec_t sort_vec(input vec_t v, input logic asc);
    word_t t;
    for (int a = 0; a < 7; a++)
      for (int b = 0; b < 7 - a; b++)
        if (asc ? (v[b] > v[b+1]) : (v[b] < v[b+1])) begin
          t = v[b]; v[b] = v[b+1]; v[b+1] = t;
        end
    return v;
  endfunction

  // Behavioural sorter: LAT enabled edges from lanes in to sorted lanes out.
  always @(posedge clk) begin
    if (sort_rst) begin
      for (int s = 0; s < LAT; s++) pipe[s] <= '0;
    end else if (sort_en) begin
      pipe[0] <= sort_vec(lanes_in, sort_dir);
      for (int s = 1; s < LAT; s++) pipe[s] <= pipe[s-1];
    end
  end

  int    n_pass = 0, n_total = 0;
  int    cyc = 0;
  bit    mon_en = 0, busy = 0, first_beat = 0, stalled = 0, hold_rdy = 0;
  word_t expq[$];
  word_t got[$];
  word_t in_words[8], lane_words[8], srt[8], fw[8], ev[8];
  int    in_cnt = 0, cur_n = 0, t_last = 0, run = 0, last_run = 0, last_lat = 0;
  logic  in_dir = 1'b0, cur_dir = 1'b0, held_last = 1'b0;
  word_t held_data = '0, last_pad_lane = '0;
  int    rdy_mode = 0, rdy_ph = 0;

  task automatic check(input string name, input word_t act, input word_t exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream ready generator: always, 1-0-0 pattern, or random.
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (hold_rdy) m_ready = 1'b0;
      else if (rdy_mode == 0) m_ready = 1'b1;
      else if (rdy_mode == 1) begin m_ready = (rdy_ph % 3 == 0); rdy_ph++; end
      else m_ready = 1'($urandom_range(1));
    end
  end

  // Compare process: frame model on the input side, expectations on the output.
  always @(negedge clk) begin
    word_t tmp;
    word_t pad;
    if (mon_en) begin
      if (m_valid === 1'b1) begin
        if (expq.size() == 0) check("m_valid_spurious", 32'(m_valid), 32'd0);
        else begin
          check("m_data", m_data, expq[0]);
          check("m_last", 32'(m_last), 32'(expq.size() == 1));
          if (first_beat) begin
            last_lat = cyc - t_last;
            check("latency", 32'(last_lat), 32'(LAT + 2));
            first_beat = 0;
          end
        end
      end
      if (stalled) begin
        check("hold_valid", 32'(m_valid), 32'd1);
        check("hold_data", m_data, held_data);
        check("hold_last", 32'(m_last), 32'(held_last));
      end
      check("s_ready", 32'(s_ready), 32'(!busy));
      if (sort_en === 1'b1) begin
        run++;
        pad = cur_dir ? '1 : '0;
        check("sort_dir", 32'(sort_dir), 32'(cur_dir));
        for (int k = 0; k < 8; k++)
          check("sort_lane", lanes_in[k], (k < cur_n) ? lane_words[k] : pad);
        last_pad_lane = lanes_in[7];
      end else if (run != 0) begin
        check("sort_en_len", 32'(run), 32'(LAT));
        last_run = run;
        run = 0;
      end
      stalled   = (m_valid === 1'b1) && (m_ready === 1'b0);
      held_data = m_data;
      held_last = m_last;
      if (m_valid === 1'b1 && m_ready === 1'b1 && reset === 1'b1 && expq.size() > 0) begin
        got.push_back(m_data);
        void'(expq.pop_front());
        if (expq.size() == 0) busy = 0;
      end
      if (s_valid === 1'b1 && s_ready === 1'b1 && reset === 1'b1) begin
        if (in_cnt == 0) in_dir = dir_cfg;
        in_words[in_cnt] = s_data;
        in_cnt++;
        if (s_last || in_cnt == 8) begin
          cur_n = in_cnt; cur_dir = in_dir;
          for (int k = 0; k < 8; k++) begin lane_words[k] = in_words[k]; srt[k] = in_words[k]; end
          for (int a = 0; a < cur_n; a++)
            for (int b = 0; b < cur_n - 1 - a; b++)
              if (cur_dir ? (srt[b] > srt[b+1]) : (srt[b] < srt[b+1])) begin
                tmp = srt[b]; srt[b] = srt[b+1]; srt[b+1] = tmp;
              end
          for (int k = 0; k < cur_n; k++) expq.push_back(srt[k]);
          busy = 1; first_beat = 1; t_last = cyc; in_cnt = 0;
        end
      end
      if (reset === 1'b0) begin
        expq.delete(); busy = 0; in_cnt = 0; stalled = 0; run = 0; first_beat = 0;
      end
    end
  end

  task automatic send_frame(input word_t w[8], input int n, input logic d,
                            input bit flip, input int gap, input bit last_full);
    int i = 0;
    int guard = 0;
    bit hs;
    got.delete();
    dir_cfg = d;
    while (i < n && guard < 2000) begin
      if (gap > 0 && $urandom_range(99) < gap) begin
        s_valid = 1'b0; s_data = $urandom; s_last = 1'($urandom_range(1));
      end else begin
        s_valid = 1'b1; s_data = w[i]; s_last = (i == n - 1) && (n < 8 || last_full);
      end
      @(negedge clk); hs = s_valid && s_ready;
      @(posedge clk); #1; guard++;
      if (hs) begin
        i++;
        if (flip && i == 1) dir_cfg = ~d;
      end
    end
    s_valid = 1'b0; s_last = 1'b0;
    if (guard >= 2000) check("send_timeout", 32'(i), 32'(n));
  endtask

  task automatic wait_done();
    int g = 0;
    while (busy && g < 500) begin @(posedge clk); #1; g++; end
    check("frame_done", 32'(busy), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic expect_out(input string tag, input word_t e[8], input int n);
    check({tag, "_beats"}, 32'(got.size()), 32'(n));
    for (int k = 0; k < n; k++) check({tag, "_word"}, (k < got.size()) ? got[k] : 'x, e[k]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int g;
    reset = 1'b0; dir_cfg = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_s_ready", 32'(s_ready), 32'd1);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_last", 32'(m_last), 32'd0);
    check("rst_m_data", m_data, 32'd0);
    check("rst_sort_en", 32'(sort_en), 32'd0);
    check("rst_sort_dir", 32'(sort_dir), 32'd0);
    check("rst_sort_rst", 32'(sort_rst), 32'd1);
    for (int k = 0; k < 8; k++) check("rst_lane", lanes_in[k], 32'd0);
    mon_en = 1;
    @(posedge clk); #1 reset = 1'b1;
    #1 check("sort_rst_released", 32'(sort_rst), 32'd0);
    @(posedge clk); #1;

    // full ascending frame
    fw = '{5, 3, 8, 1, 7, 2, 6, 4}; ev = '{1, 2, 3, 4, 5, 6, 7, 8};
    send_frame(fw, 8, 1'b1, 0, 0, 1); wait_done();
    expect_out("asc", ev, 8);
    check("asc_latency", 32'(last_lat), 32'd9);

    // full descending frame with ties
    fw = '{2, 2, 9, 0, 9, 5, 5, 1}; ev = '{9, 9, 5, 5, 2, 2, 1, 0};
    send_frame(fw, 8, 1'b0, 0, 0, 0); wait_done();
    expect_out("desc", ev, 8);

    // short frame holding the pad value itself
    fw = '{32'hFFFFFFFF, 3, 32'h10, 0, 0, 0, 0, 0}; ev = '{3, 32'h10, 32'hFFFFFFFF, 0, 0, 0, 0, 0};
    send_frame(fw, 3, 1'b1, 0, 0, 0); wait_done();
    expect_out("short", ev, 3);
    check("short_pad_lane7", last_pad_lane, 32'hFFFFFFFF);

    // single-word frame
    fw = '{42, 0, 0, 0, 0, 0, 0, 0}; ev = '{42, 0, 0, 0, 0, 0, 0, 0};
    send_frame(fw, 1, 1'b0, 0, 0, 0); wait_done();
    expect_out("single", ev, 1);

    // output backpressure 1,0,0,1,...
    rdy_mode = 1; rdy_ph = 0;
    for (int k = 0; k < 8; k++) fw[k] = $urandom;
    send_frame(fw, 8, 1'b1, 0, 0, 1); wait_done();
    check("bp_beats", 32'(got.size()), 32'd8);
    rdy_mode = 0;

    // direction flip after first word plus input gaps
    fw = '{1, 2, 3, 4, 5, 0, 0, 0}; ev = '{5, 4, 3, 2, 1, 0, 0, 0};
    send_frame(fw, 5, 1'b0, 1, 40, 0); wait_done();
    expect_out("flip", ev, 5);
    check("flip_sort_en_len", 32'(last_run), 32'd7);

    // reset in the middle of DRAIN
    fw = '{8, 7, 6, 5, 4, 3, 2, 1}; ev = '{1, 2, 3, 0, 0, 0, 0, 0};
    send_frame(fw, 8, 1'b1, 0, 0, 0);
    g = 0;
    while (got.size() < 3 && g < 200) begin @(posedge clk); g++; end
    check("rst_drain_reached", 32'(got.size()), 32'd3);
    hold_rdy = 1;
    #1 reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1; hold_rdy = 0;
    @(negedge clk);
    check("rst_drain_m_valid", 32'(m_valid), 32'd0);
    check("rst_drain_s_ready", 32'(s_ready), 32'd1);
    expect_out("rst_partial", ev, 3);
    @(posedge clk); #1;
    fw = '{4, 3, 2, 1, 0, 0, 0, 0}; ev = '{0, 0, 0, 0, 1, 2, 3, 4};
    send_frame(fw, 8, 1'b1, 0, 0, 0); wait_done();
    expect_out("after_rst", ev, 8);

    // randomized frames
    for (int f = 0; f < 24; f++) begin
      int n;
      int r;
      n = $urandom_range(8, 1);
      for (int k = 0; k < 8; k++) begin
        r = $urandom_range(9);
        if (r == 0) fw[k] = '0;
        else if (r == 1) fw[k] = '1;
        else if (r < 5) fw[k] = $urandom_range(15);
        else fw[k] = $urandom;
      end
      rdy_mode = $urandom_range(2);
      send_frame(fw, n, 1'($urandom_range(1)), 1'($urandom_range(1)),
                 $urandom_range(50), 1'($urandom_range(1)));
      wait_done();
      check("rand_beats", 32'(got.size()), 32'(n));
    end
    rdy_mode = 0;
    repeat (3) @(posedge clk);
    check("final_expq_empty", 32'(expq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
